// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite responder backed by NUM_REGS 32-bit registers with byte strobes.
// Independent write (AW+W in any order) and read FSMs; out-of-window accesses answer SLVERR.
module axi_lite_slave_regfile #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(4 * NUM_REGS);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  function automatic logic dec_hit(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off < WIN_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] dec_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  // ---------------- write side ----------------
  w_state_t              w_state, w_next;
  logic                  aw_got, w_got;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  aw_hs, w_hs, have_aw, have_w, w_commit, w_hit;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [STRB_W-1:0]     cur_strb;
  logic [IDX_W-1:0]      w_idx;

  always_ff @(posedge aclk) begin
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // A channel captured on an earlier edge is taken from its latch, otherwise from the bus.
  always_comb begin
    w_next   = w_state;
    w_commit = 1'b0;
    aw_hs    = awvalid && awready;
    w_hs     = wvalid && wready;
    have_aw  = aw_got || aw_hs;
    have_w   = w_got || w_hs;
    cur_addr = aw_got ? aw_addr_q : awaddr;
    cur_data = w_got  ? w_data_q  : wdata;
    cur_strb = w_got  ? w_strb_q  : wstrb;
    w_hit    = dec_hit(cur_addr);
    w_idx    = dec_idx(cur_addr);
    case (w_state)
      W_IDLE: if (have_aw && have_w) begin
        w_commit = 1'b1;
        w_next   = W_RESP;
      end
      W_RESP: if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      regs      <= '0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= OKAY;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (w_commit) begin
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b1;
      bresp   <= w_hit ? OKAY : SLVERR;
      if (w_hit)
        for (int k = 0; k < STRB_W; k++)
          if (cur_strb[k]) regs[w_idx][8*k +: 8] <= cur_data[8*k +: 8];
    end else if (w_state == W_IDLE) begin
      if (aw_hs) begin
        aw_got    <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_hs) begin
        w_got    <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      awready <= !have_aw;
      wready  <= !have_w;
    end else if (bready) begin
      bvalid  <= 1'b0;
      awready <= 1'b1;
      wready  <= 1'b1;
    end
  end

  // ---------------- read side ----------------
  r_state_t r_state, r_next;
  logic     ar_hs;

  always_ff @(posedge aclk) begin
    if (areset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    ar_hs  = arvalid && arready;
    case (r_state)
      R_IDLE:  if (ar_hs)  r_next = R_DATA;
      R_DATA:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // regs is sampled before this edge's write lands, so a colliding read sees old data.
  always_ff @(posedge aclk) begin
    if (areset) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
    end else if (r_state == R_IDLE) begin
      if (ar_hs) begin
        rdata   <= dec_hit(araddr) ? regs[dec_idx(araddr)] : '0;
        rresp   <= dec_hit(araddr) ? OKAY : SLVERR;
        rvalid  <= 1'b1;
        arready <= 1'b0;
      end else begin
        arready <= 1'b1;
      end
    end else if (rready) begin
      rvalid  <= 1'b0;
      arready <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Directed bench for axi_lite_slave_regfile: inputs driven and outputs sampled on the falling edge.
module tb_axi_lite_slave_regfile;
  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;

  axi_lite_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(4), .BASE_ADDR(32'h0)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1; bready = 1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      if (hs_aw) begin awvalid = 0; aw_done = 1; end
      if (hs_w)  begin wvalid = 0;  w_done = 1;  end
    end
    for (int i = 0; i < 20 && !bvalid; i++) tick();
    chk("wr_timeout", {31'b0, bvalid}, 32'd1);
    resp = bresp;
    tick();
    bready = 0; awvalid = 0; wvalid = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit done = 0, hs;
    araddr = a; arvalid = 1; rready = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      hs = arready;
      tick();
      if (hs) begin arvalid = 0; done = 1; end
    end
    for (int i = 0; i < 20 && !rvalid; i++) tick();
    chk("rd_timeout", {31'b0, rvalid}, 32'd1);
    d = rdata; resp = rresp;
    tick();
    rready = 0; arvalid = 0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rsp;

  initial begin
    areset = 1; awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    tick(); tick();
    chk("rst_awready", {31'b0, awready}, 0);
    chk("rst_wready",  {31'b0, wready},  0);
    chk("rst_arready", {31'b0, arready}, 0);
    chk("rst_bvalid",  {31'b0, bvalid},  0);
    chk("rst_rvalid",  {31'b0, rvalid},  0);
    chk("rst_rdata",   rdata, 0);
    chk("rst_bresp",   {30'b0, bresp}, 0);
    chk("rst_rresp",   {30'b0, rresp}, 0);
    areset = 0;
    tick();
    chk("post_rst_awready", {31'b0, awready}, 1);
    chk("post_rst_wready",  {31'b0, wready},  1);
    chk("post_rst_arready", {31'b0, arready}, 1);

    // same-cycle AW+W to 0x4
    awaddr = 32'h4; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("t1_bvalid",  {31'b0, bvalid}, 1);
    chk("t1_bresp",   {30'b0, bresp}, 0);
    chk("t1_awready", {31'b0, awready}, 0);
    chk("t1_wready",  {31'b0, wready}, 0);
    tick();
    bready = 0;
    chk("t1_bvalid_clr",  {31'b0, bvalid}, 0);
    chk("t1_awready_re",  {31'b0, awready}, 1);
    araddr = 32'h4; arvalid = 1;
    tick();
    arvalid = 0;
    chk("t1_rvalid",  {31'b0, rvalid}, 1);
    chk("t1_rdata",   rdata, 32'hDEADBEEF);
    chk("t1_rresp",   {30'b0, rresp}, 0);
    chk("t1_arready", {31'b0, arready}, 0);
    rready = 1;
    tick();
    rready = 0;
    chk("t1_rvalid_clr", {31'b0, rvalid}, 0);
    chk("t1_arready_re", {31'b0, arready}, 1);

    // W ahead of AW, strobe 0x5 onto reg2
    wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1;
    tick();
    wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_wready_wait", {31'b0, wready}, 0);
      chk("t2_bvalid_wait", {31'b0, bvalid}, 0);
      chk("t2_awready_up",  {31'b0, awready}, 1);
      if (i < 2) tick();
    end
    awaddr = 32'h8; awvalid = 1; bready = 1;
    tick();
    awvalid = 0;
    chk("t2_bvalid", {31'b0, bvalid}, 1);
    chk("t2_bresp",  {30'b0, bresp}, 0);
    tick();
    bready = 0;
    axi_read(32'h8, rd, rsp);
    chk("t2_rdata", rd, 32'h00220044);
    chk("t2_rresp", {30'b0, rsp}, 0);

    // out-of-window write and read
    axi_write(32'h10, 32'hFFFFFFFF, 4'hF, rsp);
    chk("t3_bresp", {30'b0, rsp}, 2);
    axi_read(32'h0, rd, rsp);  chk("t3_reg0", rd, 32'h0);
    axi_read(32'h4, rd, rsp);  chk("t3_reg1", rd, 32'hDEADBEEF);
    axi_read(32'h8, rd, rsp);  chk("t3_reg2", rd, 32'h00220044);
    axi_read(32'hC, rd, rsp);  chk("t3_reg3", rd, 32'h0);
    axi_read(32'h14, rd, rsp);
    chk("t3_miss_rdata", rd, 32'h0);
    chk("t3_miss_rresp", {30'b0, rsp}, 2);

    // wstrb=0 leaves the register alone with OKAY
    axi_write(32'h4, 32'h12345678, 4'h0, rsp);
    chk("strb0_bresp", {30'b0, rsp}, 0);
    axi_read(32'h4, rd, rsp);
    chk("strb0_rdata", rd, 32'hDEADBEEF);

    // backpressure on B then R
    awaddr = 32'hC; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    tick();
    awvalid = 0; wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_bvalid_hold", {31'b0, bvalid}, 1);
      chk("t4_bresp_hold",  {30'b0, bresp}, 0);
      chk("t4_awready_lo",  {31'b0, awready}, 0);
      chk("t4_wready_lo",   {31'b0, wready}, 0);
      tick();
    end
    bready = 1;
    tick();
    bready = 0;
    chk("t4_bvalid_clr", {31'b0, bvalid}, 0);
    araddr = 32'h4; arvalid = 1; rready = 0;
    tick();
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_rvalid_hold", {31'b0, rvalid}, 1);
      chk("t4_rdata_hold",  rdata, 32'hDEADBEEF);
      chk("t4_rresp_hold",  {30'b0, rresp}, 0);
      chk("t4_arready_lo",  {31'b0, arready}, 0);
      tick();
    end
    rready = 1;
    tick();
    rready = 0;
    chk("t4_rvalid_clr", {31'b0, rvalid}, 0);

    // read and write to 0xC on the same edge
    awaddr = 32'hC; wdata = 32'h0; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    araddr = 32'hC; arvalid = 1; rready = 0;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("t5_bvalid", {31'b0, bvalid}, 1);
    chk("t5_rvalid", {31'b0, rvalid}, 1);
    chk("t5_old",    rdata, 32'hA5A5A5A5);
    rready = 1;
    tick();
    rready = 0; bready = 0;
    axi_read(32'hC, rd, rsp);
    chk("t5_new", rd, 32'h0);

    // reset while both sides wait on their response
    awaddr = 32'h8; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    araddr = 32'h4; arvalid = 1; rready = 0;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("t6_bvalid_pre", {31'b0, bvalid}, 1);
    chk("t6_rvalid_pre", {31'b0, rvalid}, 1);
    areset = 1;
    tick();
    chk("t6_bvalid", {31'b0, bvalid}, 0);
    chk("t6_rvalid", {31'b0, rvalid}, 0);
    chk("t6_arready", {31'b0, arready}, 0);
    areset = 0;
    tick();
    chk("t6_awready_re", {31'b0, awready}, 1);
    for (int i = 0; i < 4; i++) begin
      axi_read(32'(4 * i), rd, rsp);
      chk("t6_reg_clr", rd, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_lite_slave_regfile.md
Name: axi_lite_slave_regfile

Overview:
AXI4-Lite responder that terminates one slave port of the AXI4-Lite interconnect with a bank of 32-bit read/write registers. It accepts AW and W in either order and applies WSTRB byte enables. Independent read and write FSMs allow a read and a write to be in flight at once. Out-of-window addresses return SLVERR, so interconnect routing and default-slave handling can be checked end to end.

Parameters:
ADDR_WIDTH, 32, width of awaddr/araddr
DATA_WIDTH, 32, register and data-bus width; only 32 supported
NUM_REGS, 4, number of 32-bit registers
BASE_ADDR, 32'h0, byte address of register 0; window is BASE_ADDR to BASE_ADDR+4*NUM_REGS-1

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  synchronous active-high reset
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  write byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready

Behaviour:
- Reset (areset=1 at an aclk edge): all registers 0; awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; both FSMs go to IDLE. Reset mid-transaction drops it with no response. Readies rise in the first cycle after reset deasserts.
- Decode: hit when BASE_ADDR <= addr < BASE_ADDR+4*NUM_REGS; index = (addr-BASE_ADDR)>>2; addr[1:0] ignored. Miss: resp = 2'b10 (SLVERR); otherwise 2'b00 (OKAY).
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. Each handshake latches its channel and drops its ready the next cycle.
  - Same-cycle AW and W handshakes are legal.
  - On the edge where both are captured, the register is written, bvalid=1, bresp is set, and the FSM enters W_RESP. Latency from the later handshake to bvalid is 1 cycle.
  - Byte k is written only when wstrb[k]=1; wstrb=0 leaves the register unchanged with OKAY.
  - Miss: no register is changed; SLVERR.
  - W_RESP: awready=wready=0; hold bvalid and bresp stable until bready=1, then clear bvalid, return to W_IDLE, and re-raise both readies the next cycle.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On handshake, rdata = reg[index] (0 on miss), rresp is set, rvalid=1 next cycle, FSM enters R_DATA, arready=0.
  - R_DATA: hold rdata, rresp and rvalid until rready=1, then return to R_IDLE with arready=1 the next cycle.
- Simultaneous read and write to the same register: the read returns the value held before the write commits on that edge (old data).
- Back-to-back: maximum throughput is one transaction per 2 cycles per channel. No outstanding-transaction queue.
- Protocol: valid/resp/data are never withdrawn before their handshake completes. No combinational path from any input to any output.

Test Plan:
- Reset, then AW(0x4) and W(0xDEADBEEF, strb 0xF) in the same cycle; bready=1 -> bvalid one cycle later with bresp=00; read 0x4 -> rdata=0xDEADBEEF, rresp=00, rvalid one cycle after the AR handshake.
- W(0x11223344, strb 0x5) three cycles before AW(0x8), onto reg2=0 -> reg2=0x00220044; wready is low while waiting for AW.
- Write to 0x10 with BASE_ADDR=0, NUM_REGS=4 -> bresp=10, all registers unchanged; read 0x14 -> rdata=0, rresp=10.
- Hold bready=0 for 5 cycles, then rready=0 for 5 cycles -> bvalid/bresp and rvalid/rdata/rresp stay stable; awready, wready and arready stay 0 until each handshake completes.
- Read and write to 0xC on the same edge (old value 0xA5A5A5A5, new 0x0) -> rdata=0xA5A5A5A5; a following read returns 0x0.
- Assert areset while in W_RESP and R_DATA -> next cycle bvalid=rvalid=0 and all registers are 0.
